// File: rtl/decode_if.sv
// Fetch/execute-facing bundle of the decode stage: instruction and bundle
// handshakes, register-file read bus, writeback port and stall counter.
interface decode_if #(
    parameter int INSN_W = 16,
    parameter int OP_W   = 4,
    parameter int NREGS  = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = $clog2(NREGS);

    logic                    in_valid;
    logic                    in_ready;
    logic [INSN_W-1:0]       in_insn;
    logic [NREGS*DATA_W-1:0] regs;
    logic                    wb_valid;
    logic [IDX_W-1:0]        wb_idx;
    logic [DATA_W-1:0]       wb_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OP_W-1:0]         out_opcode;
    logic [DATA_W-1:0]       out_src1;
    logic [DATA_W-1:0]       out_src2;
    logic [IDX_W-1:0]        out_dst;
    logic [DATA_W-1:0]       out_imm;
    logic                    out_use_imm;
    logic [15:0]             stall_cnt;

    modport master (
        output in_valid, in_insn, regs, wb_valid, wb_idx, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_src1, out_src2, out_dst,
               out_imm, out_use_imm, stall_cnt
    );

    modport slave (
        input  in_valid, in_insn, regs, wb_valid, wb_idx, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_src1, out_src2, out_dst,
               out_imm, out_use_imm, stall_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode: field split, operand read with writeback
// forwarding, in-flight destination scoreboard and RAW/WAW stall.
module decode_stage #(
    parameter int INSN_W     = 16,
    parameter int OP_W       = 4,
    parameter int NREGS      = 4,
    parameter int DATA_W     = 8,
    parameter int OP_NOP     = 0,
    parameter int OP_MOV_IMM = 8
) (
    input logic     clk,
    input logic     rst,
    decode_if.slave bus
);
    localparam int IDX_W = $clog2(NREGS);
    localparam int IMM_W = INSN_W - OP_W - 2*IDX_W;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] fit_imm(input logic [IMM_W-1:0] imm);
        logic [IMM_W+DATA_W-1:0] ext;
        ext = {{DATA_W{1'b0}}, imm};
        return ext[DATA_W-1:0];
    endfunction

    // p0: combinational decode of the presented instruction
    logic [OP_W-1:0]   op_p0;
    logic [IDX_W-1:0]  dst_p0;
    logic [IDX_W-1:0]  src2_p0;
    logic [IMM_W-1:0]  imm_p0;
    logic [DATA_W-1:0] src1_val_p0;
    logic [DATA_W-1:0] src2_val_p0;
    logic              uses_src_p0;
    logic              writes_p0;
    logic              hazard_p0;
    logic              accept_p0;
    logic              wb_ok;
    logic              wb_hit;
    logic [NREGS-1:0]  wb_mask;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  pend_eff;
    logic [NREGS-1:0]  pending;

    logic              vld_p1;
    logic [OP_W-1:0]   opcode_p1;
    logic [DATA_W-1:0] src1_p1;
    logic [DATA_W-1:0] src2_p1;
    logic [IDX_W-1:0]  dst_p1;
    logic [DATA_W-1:0] imm_p1;
    logic              use_imm_p1;
    logic [15:0]       stall_cnt_p1;

    assign op_p0   = bus.in_insn[INSN_W-1 -: OP_W];
    assign dst_p0  = bus.in_insn[INSN_W-OP_W-1 -: IDX_W];
    assign src2_p0 = bus.in_insn[IMM_W +: IDX_W];
    assign imm_p0  = bus.in_insn[IMM_W-1:0];

    // Writeback indices beyond the register file are ignored entirely.
    if ((1 << IDX_W) == NREGS) begin : g_wb_full
        assign wb_ok = 1'b1;
    end else begin : g_wb_part
        assign wb_ok = (int'(bus.wb_idx) < NREGS);
    end
    assign wb_hit = bus.wb_valid && wb_ok;

    always_comb begin
        wb_mask     = '0;
        src1_val_p0 = '0;
        src2_val_p0 = '0;
        for (int i = 0; i < NREGS; i++) begin
            wb_mask[i] = wb_hit && (bus.wb_idx == IDX_W'(i));
            if (dst_p0 == IDX_W'(i))  src1_val_p0 = bus.regs[i*DATA_W +: DATA_W];
            if (src2_p0 == IDX_W'(i)) src2_val_p0 = bus.regs[i*DATA_W +: DATA_W];
        end
        if (wb_hit && (bus.wb_idx == dst_p0))  src1_val_p0 = bus.wb_data;
        if (wb_hit && (bus.wb_idx == src2_p0)) src2_val_p0 = bus.wb_data;
    end

    // A register being written back this cycle no longer blocks its readers.
    assign pend_eff    = pending & ~wb_mask;
    assign uses_src_p0 = (op_p0 != OP_W'(OP_NOP)) && (op_p0 != OP_W'(OP_MOV_IMM));
    assign writes_p0   = (op_p0 != OP_W'(OP_NOP));
    assign hazard_p0   = bus.in_valid &&
                         ((uses_src_p0 && (pend_eff[dst_p0] || pend_eff[src2_p0])) ||
                          (writes_p0 && pend_eff[dst_p0]));
    assign bus.in_ready = (!vld_p1 || bus.out_ready) && !hazard_p0;
    assign accept_p0    = bus.in_valid && bus.in_ready;
    assign set_mask     = (accept_p0 && writes_p0) ? (NREGS'(1) << dst_p0) : '0;

    // p1: registered bundle, scoreboard and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            opcode_p1    <= '0;
            src1_p1      <= '0;
            src2_p1      <= '0;
            dst_p1       <= '0;
            imm_p1       <= '0;
            use_imm_p1   <= 1'b0;
            pending      <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1     <= 1'b1;
                opcode_p1  <= op_p0;
                src1_p1    <= src1_val_p0;
                src2_p1    <= src2_val_p0;
                dst_p1     <= dst_p0;
                imm_p1     <= fit_imm(imm_p0);
                use_imm_p1 <= (op_p0 == OP_W'(OP_MOV_IMM));
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            pending <= (pending & ~wb_mask) | set_mask;
            if (hazard_p0) stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_opcode  = opcode_p1;
    assign bus.out_src1    = src1_p1;
    assign bus.out_src2    = src2_p1;
    assign bus.out_dst     = dst_p1;
    assign bus.out_imm     = imm_p1;
    assign bus.out_use_imm = use_imm_p1;
    assign bus.stall_cnt   = stall_cnt_p1;
endmodule
